// File: rtl/instruction_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// controlpath_pkg
// Shared definitions for the RAPIDS instruction sequencer control path:
//   - FSM state encoding (S_IDLE .. S_HALT)
//   - trap cause codes (TRAP_NONE, TRAP_INVALID, TRAP_TIMEOUT)
//   - instruction word width
// -----------------------------------------------------------------------------
package controlpath_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned CNT_WIDTH   = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_INVALID = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

endpackage

// File: rtl/instruction_sequencer_if.sv
// -----------------------------------------------------------------------------
// instruction_sequencer_if
// Groups the instruction-memory handshake and the decoder/ALU handshake that
// the sequencer drives.
//   master : sequencer side (drives imem_req/imem_addr/instruction/alu_start/
//            alu_write, samples imem_ack/imem_data/invalid_instruction/
//            alu_done/alu_write_req)
//   slave  : memory / decoder / ALU side (mirror directions)
// -----------------------------------------------------------------------------
interface instruction_sequencer_if #(
    parameter int unsigned PC_WIDTH = 32
) ();
    import controlpath_pkg::*;

    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   invalid_instruction;
    logic                   alu_start;
    logic                   alu_done;
    logic [1:0]             alu_write_req;
    logic [1:0]             alu_write;

    modport master (
        output imem_req, imem_addr, instruction, alu_start, alu_write,
        input  imem_ack, imem_data, invalid_instruction, alu_done, alu_write_req
    );

    modport slave (
        input  imem_req, imem_addr, instruction, alu_start, alu_write,
        output imem_ack, imem_data, invalid_instruction, alu_done, alu_write_req
    );

endinterface

// File: rtl/instruction_sequencer_program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Holds the program counter. Loads RESET_PC on synchronous reset and advances
// by PC_STEP (modulo 2^PC_WIDTH) on each cycle where inc is high.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   inc   : advance strobe (one cycle per retired instruction)
//   pc    : current program counter
// -----------------------------------------------------------------------------
module program_counter #(
    parameter int unsigned PC_WIDTH = 32,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_INCR = PC_WIDTH'(PC_STEP);

    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] pc_q;

    // Next PC: the add truncates to PC_WIDTH, so the counter wraps silently.
    always_comb begin
        pc_d = pc_q;
        if (inc) begin
            pc_d = pc_q + PC_INCR;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset to the boot address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_INIT;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
// Fetch / decode / execute / writeback sequencer for the RAPIDS datapath.
// Fetches one instruction word per iteration over a req/ack handshake, holds it
// in the instruction register for the decoder, pulses alu_start, waits for
// alu_done (bounded by EXEC_TIMEOUT), gates register writeback and advances
// the PC. Invalid instructions and ALU timeouts trap into a sticky HALT.
//   clk, reset  : clock and synchronous active-high reset
//   run         : keep issuing instructions while high
//   bus         : imem/decoder/ALU handshakes (master modport)
//   pc_inc      : one-cycle pulse when the PC advances
//   pc          : current program counter (also drives imem_addr)
//   halted      : sticky halt flag
//   trap_cause  : 0 none, 1 invalid instruction, 2 execute timeout
//   state       : current FSM state for debug
// -----------------------------------------------------------------------------
module instruction_sequencer
    import controlpath_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 32,
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] PC_STEP      = 32'd1,
    parameter int unsigned EXEC_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    instruction_sequencer_if.master bus,
    output logic                    pc_inc,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    halted,
    output logic [1:0]              trap_cause,
    output logic [2:0]              state
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(EXEC_TIMEOUT);

    state_e                 state_d, state_q;
    logic [INSTR_WIDTH-1:0] instr_d, instr_q;
    logic [CNT_WIDTH-1:0]   cnt_d, cnt_q;
    logic [1:0]             trap_d, trap_q;
    logic                   halted_d, halted_q;

    logic                   imem_req_s;
    logic                   alu_start_s;
    logic [1:0]             alu_write_s;
    logic                   pc_inc_s;
    logic [PC_WIDTH-1:0]    pc_s;

    // Next-state, datapath register updates and state-decoded strobes.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        trap_d      = trap_q;
        halted_d    = halted_q;
        imem_req_s  = 1'b0;
        alu_start_s = 1'b0;
        alu_write_s = 2'b00;
        pc_inc_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_FETCH: begin
                // Request stays up at the current pc until memory answers.
                imem_req_s = 1'b1;
                if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_DECODE: begin
                if (bus.invalid_instruction) begin
                    state_d  = S_HALT;
                    trap_d   = TRAP_INVALID;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                    cnt_d   = {CNT_WIDTH{1'b0}};
                end
            end

            S_EXECUTE: begin
                // Counter is zero only on entry, so it doubles as the
                // first-cycle marker for the start pulse.
                if (cnt_q == {CNT_WIDTH{1'b0}}) begin
                    alu_start_s = 1'b1;
                end else begin
                    alu_start_s = 1'b0;
                end
                // alu_done has priority over the timeout check.
                if (bus.alu_done) begin
                    state_d = S_WRITEBACK;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d  = S_HALT;
                    trap_d   = TRAP_TIMEOUT;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end

            S_WRITEBACK: begin
                alu_write_s = bus.alu_write_req;
                pc_inc_s    = 1'b1;
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_HALT: begin
                state_d  = S_HALT;
                halted_d = 1'b1;
            end

            default: begin
                // Unused encodings park in HALT; trap cause is left as-is.
                state_d  = S_HALT;
                halted_d = 1'b1;
            end
        endcase
    end

    // Control-path registers: state, instruction, timeout counter, trap info.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            instr_q  <= {INSTR_WIDTH{1'b0}};
            cnt_q    <= {CNT_WIDTH{1'b0}};
            trap_q   <= TRAP_NONE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            cnt_q    <= cnt_d;
            trap_q   <= trap_d;
            halted_q <= halted_d;
        end
    end

    program_counter #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_inc_s),
        .pc    (pc_s)
    );

    assign bus.imem_req    = imem_req_s;
    assign bus.imem_addr   = pc_s;
    assign bus.instruction = instr_q;
    assign bus.alu_start   = alu_start_s;
    assign bus.alu_write   = alu_write_s;

    assign pc_inc     = pc_inc_s;
    assign pc         = pc_s;
    assign halted     = halted_q;
    assign trap_cause = trap_q;
    assign state      = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        run_w;
    logic        pc_inc, halted;
    logic [31:0] pc;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic        pc_inc_w, halted_w;
    logic [3:0]  pc_w;
    logic [1:0]  trap_cause_w;
    logic [2:0]  state_w;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;

    always #5 clk = ~clk;

    instruction_sequencer_if #(.PC_WIDTH(32)) bus ();
    instruction_sequencer_if #(.PC_WIDTH(4))  bus_w ();

    instruction_sequencer #(
        .PC_WIDTH(32), .RESET_PC(32'd0), .PC_STEP(32'd1), .EXEC_TIMEOUT(4)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .bus(bus), .pc_inc(pc_inc),
        .pc(pc), .halted(halted), .trap_cause(trap_cause), .state(state)
    );

    instruction_sequencer #(
        .PC_WIDTH(4), .RESET_PC(32'd15), .PC_STEP(32'd1), .EXEC_TIMEOUT(4)
    ) dut_w (
        .clk(clk), .reset(reset), .run(run_w), .bus(bus_w), .pc_inc(pc_inc_w),
        .pc(pc_w), .halted(halted_w), .trap_cause(trap_cause_w), .state(state_w)
    );

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        run_w = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", state, ST_IDLE); end
        n_tests++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %0h exp 0", pc); end
        n_tests++; if (bus.instruction !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %0h exp 0", bus.instruction); end
        n_tests++; if (halted !== 1'b0 || trap_cause !== 2'd0) begin n_fail++; $display("FAIL reset_trap got halted=%0b trap=%0d exp 0/0", halted, trap_cause); end
        n_tests++; if ({bus.imem_req, bus.alu_start, bus.alu_write, pc_inc} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes got %b exp 00000", {bus.imem_req, bus.alu_start, bus.alu_write, pc_inc}); end
        n_tests++; if (pc_w !== 4'd15) begin n_fail++; $display("FAIL reset_pc_w got %0d exp 15", pc_w); end
    endtask

    task automatic test_sequence();
        bus.imem_ack = 1'b1; bus.alu_done = 1'b1; bus.alu_write_req = 2'b01;
        bus.invalid_instruction = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.imem_data = 32'hA5A5_0000 | i;
            n_tests++; if (state !== ST_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== i || pc !== i) begin n_fail++; $display("FAIL seq_fetch[%0d] got st=%0d req=%0b addr=%0h exp st=1 req=1 addr=%0h", i, state, bus.imem_req, bus.imem_addr, i); end
            n_tests++; if (pc_inc !== 1'b0 || bus.alu_write !== 2'b00) begin n_fail++; $display("FAIL seq_fetch_strobe[%0d] got inc=%0b wr=%b exp 0/00", i, pc_inc, bus.alu_write); end
            @(negedge clk);
            n_tests++; if (state !== ST_DECODE || bus.instruction !== (32'hA5A5_0000 | i)) begin n_fail++; $display("FAIL seq_decode[%0d] got st=%0d ir=%0h exp st=2 ir=%0h", i, state, bus.instruction, 32'hA5A5_0000 | i); end
            @(negedge clk);
            n_tests++; if (state !== ST_EXEC || bus.alu_start !== 1'b1 || bus.alu_write !== 2'b00) begin n_fail++; $display("FAIL seq_exec[%0d] got st=%0d start=%0b wr=%b exp 3/1/00", i, state, bus.alu_start, bus.alu_write); end
            @(negedge clk);
            n_tests++; if (state !== ST_WB || bus.alu_write !== 2'b01 || pc_inc !== 1'b1 || pc !== i || bus.alu_start !== 1'b0) begin n_fail++; $display("FAIL seq_wb[%0d] got st=%0d wr=%b inc=%0b pc=%0h exp 4/01/1/%0h", i, state, bus.alu_write, pc_inc, pc, i); end
            if (i == 3) run = 1'b0;
        end
        @(negedge clk);
        n_tests++; if (state !== ST_IDLE || pc !== 32'd4 || bus.imem_req !== 1'b0 || pc_inc !== 1'b0) begin n_fail++; $display("FAIL seq_idle got st=%0d pc=%0h req=%0b inc=%0b exp 0/4/0/0", state, pc, bus.imem_req, pc_inc); end
    endtask

    task automatic test_fetch_wait();
        bus.imem_ack = 1'b0; bus.imem_data = 32'hDEAD_BEEF; bus.alu_done = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++; if (state !== ST_FETCH || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd4) begin n_fail++; $display("FAIL wait_fetch[%0d] got st=%0d req=%0b addr=%0h exp 1/1/4", k, state, bus.imem_req, bus.imem_addr); end
            if (k == 3) bus.imem_ack = 1'b1;
        end
        @(negedge clk);
        n_tests++; if (state !== ST_DECODE || bus.instruction !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wait_decode got st=%0d ir=%0h exp 2/deadbeef", state, bus.instruction); end
        run = 1'b0;
        bus.imem_data = 32'h0BAD_0BAD;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (state !== ST_WB || pc_inc !== 1'b1) begin n_fail++; $display("FAIL wait_wb got st=%0d inc=%0b exp 4/1", state, pc_inc); end
        @(negedge clk);
        @(negedge clk);
        // ack still high while idle: must not disturb the instruction register
        n_tests++; if (state !== ST_IDLE || pc !== 32'd5 || bus.instruction !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ack_outside_fetch got st=%0d pc=%0h ir=%0h exp 0/5/deadbeef", state, pc, bus.instruction); end
    endtask

    task automatic test_timeout();
        bus.imem_ack = 1'b1; bus.alu_done = 1'b0; bus.imem_data = 32'h1234_5678;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_tests++; if (state !== ST_EXEC || bus.alu_start !== (c == 1)) begin n_fail++; $display("FAIL tmo_exec[%0d] got st=%0d start=%0b exp 3/%0b", c, state, bus.alu_start, c == 1); end
        end
        @(negedge clk);
        n_tests++; if (state !== ST_HALT || halted !== 1'b1 || trap_cause !== 2'd2 || pc !== 32'd5) begin n_fail++; $display("FAIL tmo_halt got st=%0d h=%0b trap=%0d pc=%0h exp 5/1/2/5", state, halted, trap_cause, pc); end
        do_reset();
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_tests++; if (state !== ST_EXEC) begin n_fail++; $display("FAIL tmo_done_exec[%0d] got st=%0d exp 3", c, state); end
            if (c == 5) bus.alu_done = 1'b1;
        end
        @(negedge clk);
        n_tests++; if (state !== ST_WB || trap_cause !== 2'd0 || halted !== 1'b0 || pc_inc !== 1'b1) begin n_fail++; $display("FAIL tmo_done_wb got st=%0d trap=%0d h=%0b inc=%0b exp 4/0/0/1", state, trap_cause, halted, pc_inc); end
        run = 1'b0;
        @(negedge clk);
        n_tests++; if (state !== ST_IDLE || pc !== 32'd1) begin n_fail++; $display("FAIL tmo_done_idle got st=%0d pc=%0h exp 0/1", state, pc); end
    endtask

    task automatic test_invalid();
        bus.imem_ack = 1'b1; bus.alu_done = 1'b1; bus.imem_data = 32'hFFFF_FFFF;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.invalid_instruction = 1'b1;
        @(negedge clk);
        n_tests++; if (state !== ST_HALT || halted !== 1'b1 || trap_cause !== 2'd1 || pc !== 32'd1 || bus.alu_start !== 1'b0) begin n_fail++; $display("FAIL inv_halt got st=%0d h=%0b trap=%0d pc=%0h exp 5/1/1/1", state, halted, trap_cause, pc); end
        bus.invalid_instruction = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (state !== ST_HALT || pc !== 32'd1 || bus.imem_req !== 1'b0 || bus.instruction !== 32'hFFFF_FFFF || trap_cause !== 2'd1) begin n_fail++; $display("FAIL inv_sticky got st=%0d pc=%0h req=%0b ir=%0h exp 5/1/0/ffffffff", state, pc, bus.imem_req, bus.instruction); end
        do_reset();
        n_tests++; if (state !== ST_IDLE || pc !== 32'd0 || halted !== 1'b0 || trap_cause !== 2'd0) begin n_fail++; $display("FAIL inv_reset got st=%0d pc=%0h h=%0b trap=%0d exp 0/0/0/0", state, pc, halted, trap_cause); end
    endtask

    task automatic test_reset_mid_fetch();
        bus.imem_ack = 1'b1; bus.alu_done = 1'b1; bus.imem_data = 32'h0000_0042;
        run = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++; if (state !== ST_FETCH || pc !== 32'd1 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_pre got st=%0d pc=%0h req=%0b exp 1/1/1", state, pc, bus.imem_req); end
        bus.imem_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (state !== ST_IDLE || bus.imem_req !== 1'b0 || pc !== 32'd0) begin n_fail++; $display("FAIL rst_fetch got st=%0d req=%0b pc=%0h exp 0/0/0", state, bus.imem_req, pc); end
        reset = 1'b0;
        run   = 1'b0;
    endtask

    task automatic test_wrap();
        run_w = 1'b1;
        @(negedge clk);
        n_tests++; if (state_w !== ST_FETCH || bus_w.imem_addr !== 4'd15) begin n_fail++; $display("FAIL wrap_fetch got st=%0d addr=%0d exp 1/15", state_w, bus_w.imem_addr); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (state_w !== ST_WB || bus_w.alu_write !== 2'b10 || pc_w !== 4'd15) begin n_fail++; $display("FAIL wrap_wb got st=%0d wr=%b pc=%0d exp 4/10/15", state_w, bus_w.alu_write, pc_w); end
        run_w = 1'b0;
        @(negedge clk);
        n_tests++; if (state_w !== ST_IDLE || pc_w !== 4'd0) begin n_fail++; $display("FAIL wrap_pc got st=%0d pc=%0d exp 0/0", state_w, pc_w); end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; run_w = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_data = 32'd0; bus.invalid_instruction = 1'b0;
        bus.alu_done = 1'b0; bus.alu_write_req = 2'b00;
        bus_w.imem_ack = 1'b1; bus_w.imem_data = 32'h0000_0007; bus_w.invalid_instruction = 1'b0;
        bus_w.alu_done = 1'b1; bus_w.alu_write_req = 2'b10;
        test_reset();
        test_sequence();
        test_fetch_wait();
        test_timeout();
        test_invalid();
        test_reset_mid_fetch();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
